// File: rtl/serial_adder_ctrl.sv
// Sequencer for a bit-serial adder: latches operands, drives two external
// operand shift registers, and accumulates the sum LSB-first with a carry flop.
module serial_adder_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             sr_load,
    output logic             sr_enable,
    output logic [WIDTH-1:0] sr_a_data,
    output logic [WIDTH-1:0] sr_b_data,
    input  logic             a_bit,
    input  logic             b_bit,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum_out,
    output logic             cout
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_SHIFT = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t           r_state;
    logic             r_carry;
    logic [CNT_W-1:0] r_count;
    logic [WIDTH-1:0] r_res;

    logic             w_sum;
    logic             w_carry;
    logic [WIDTH-1:0] w_res_next;

    // Full adder on the current serial bits; sum bits enter at the MSB so the
    // first (LSB) bit ends up in bit 0 after WIDTH shifts.
    assign w_sum      = a_bit ^ b_bit ^ r_carry;
    assign w_carry    = (a_bit & b_bit) | (a_bit & r_carry) | (b_bit & r_carry);
    assign w_res_next = {w_sum, r_res[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_carry   <= 1'b0;
            r_count   <= '0;
            r_res     <= '0;
            sr_load   <= 1'b0;
            sr_enable <= 1'b0;
            sr_a_data <= '0;
            sr_b_data <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            sum_out   <= '0;
            cout      <= 1'b0;
        end else begin
            sr_load   <= 1'b0;
            sr_enable <= 1'b0;
            done      <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        sr_a_data <= a_in;
                        sr_b_data <= b_in;
                        sr_load   <= 1'b1;
                        busy      <= 1'b1;
                        r_state   <= S_LOAD;
                    end else begin
                        busy      <= 1'b0;
                    end
                end
                S_LOAD: begin
                    r_carry   <= 1'b0;
                    r_count   <= '0;
                    sr_enable <= 1'b1;
                    r_state   <= S_SHIFT;
                end
                S_SHIFT: begin
                    r_carry <= w_carry;
                    r_res   <= w_res_next;
                    r_count <= r_count + 1'b1;
                    // Publish only the finished word so sum_out never shows partials.
                    if (r_count == LAST_BIT) begin
                        sum_out <= w_res_next;
                        cout    <= w_carry;
                        done    <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        sr_enable <= 1'b1;
                    end
                end
                S_DONE: begin
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Bench for serial_adder_ctrl: behavioural shift registers, a timing/arithmetic
// reference model checked every cycle, plus directed literal expectations.
module tb_serial_adder_ctrl;

    localparam int WIDTH = 8;
    localparam int CNT_W = 3;
    localparam int LAT   = WIDTH + 2;

    logic             clk   = 1'b0;
    logic             rst   = 1'b0;
    logic             start = 1'b0;
    logic [WIDTH-1:0] a_in  = '0;
    logic [WIDTH-1:0] b_in  = '0;
    logic             sr_load, sr_enable, busy, done, cout;
    logic [WIDTH-1:0] sr_a_data, sr_b_data, sum_out;
    logic             a_bit, b_bit;
    logic [WIDTH-1:0] sra = '0;
    logic [WIDTH-1:0] srb = '0;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int done_cnt = 0;
    int load_cnt = 0;
    int en_cnt   = 0;
    int done_times[$];

    always #5 clk = ~clk;

    serial_adder_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .a_in     (a_in),
        .b_in     (b_in),
        .sr_load  (sr_load),
        .sr_enable(sr_enable),
        .sr_a_data(sr_a_data),
        .sr_b_data(sr_b_data),
        .a_bit    (a_bit),
        .b_bit    (b_bit),
        .busy     (busy),
        .done     (done),
        .sum_out  (sum_out),
        .cout     (cout)
    );

    // Operand shift registers: load presents LSB, enable moves to next bit.
    always @(posedge clk) begin
        if (sr_load) begin
            sra <= sr_a_data;
            srb <= sr_b_data;
        end else if (sr_enable) begin
            sra <= sra >> 1;
            srb <= srb >> 1;
        end
    end
    assign a_bit = sra[0];
    assign b_bit = srb[0];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Model: m_t counts cycles since the accepted start (0 = idle).
    int               m_t = 0;
    logic [WIDTH-1:0] m_a = '0, m_b = '0, m_sum = '0;
    logic             m_cout = 1'b0;
    bit               check_en = 1'b0;

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        check_en <= 1'b1;
        if (!rst) begin
            m_t    <= 0;
            m_a    <= '0;
            m_b    <= '0;
            m_sum  <= '0;
            m_cout <= 1'b0;
        end else if (m_t == 0) begin
            if (start) begin
                m_t <= 1;
                m_a <= a_in;
                m_b <= b_in;
            end
        end else if (m_t == LAT) begin
            m_t <= 0;
        end else begin
            m_t <= m_t + 1;
            if (m_t == LAT - 1)
                {m_cout, m_sum} <= {1'b0, m_a} + {1'b0, m_b};
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            chk("busy",      busy,      m_t != 0);
            chk("sr_load",   sr_load,   m_t == 1);
            chk("sr_enable", sr_enable, (m_t >= 2) && (m_t <= LAT - 1));
            chk("done",      done,      m_t == LAT);
            chk("sr_a_data", sr_a_data, m_a);
            chk("sr_b_data", sr_b_data, m_b);
            chk("sum_out",   sum_out,   m_sum);
            chk("cout",      cout,      m_cout);
            if (done) begin
                done_cnt++;
                done_times.push_back(cyc);
            end
            if (sr_load)   load_cnt++;
            if (sr_enable) en_cnt++;
        end
    end

    task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic [WIDTH-1:0] es, input logic ec, input string nm);
        int n;
        @(negedge clk);
        a_in  = a;
        b_in  = b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 1;
        while (!done && n < 30) begin
            @(negedge clk);
            n++;
        end
        if (!done) begin
            chk({nm, "_timeout"}, 0, 1);
        end else begin
            chk({nm, "_latency"}, n, LAT);
            chk({nm, "_sum"}, sum_out, es);
            chk({nm, "_cout"}, cout, ec);
        end
        @(negedge clk);
    endtask

    initial begin
        int d0, l0, e0, q0;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_sum", sum_out, 8'h00);
        chk("rst_busy", busy, 1'b0);
        rst = 1'b1;

        l0 = load_cnt; e0 = en_cnt;
        run_op(8'h35, 8'h4A, 8'h7F, 1'b0, "basic");
        chk("basic_load_cycles", load_cnt - l0, 1);
        chk("basic_enable_cycles", en_cnt - e0, WIDTH);
        run_op(8'hFF, 8'h01, 8'h00, 1'b1, "wrap");
        run_op(8'hFF, 8'hFF, 8'hFE, 1'b1, "max");

        // Second start mid-SHIFT must be ignored.
        d0 = done_cnt;
        @(negedge clk);
        a_in = 8'h10; b_in = 8'h20; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        a_in = 8'h01; b_in = 8'h01; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (20) begin
            if (done) begin
                chk("busy_start_sum", sum_out, 8'h30);
                chk("busy_start_cout", cout, 1'b0);
            end
            @(negedge clk);
        end
        chk("busy_start_dones", done_cnt - d0, 1);

        // Reset during the 4th SHIFT cycle discards the operation.
        d0 = done_cnt;
        a_in = 8'h77; b_in = 8'h11; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        chk("midrst_sum", sum_out, 8'h00);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_enable", sr_enable, 1'b0);
        chk("midrst_a_data", sr_a_data, 8'h00);
        repeat (15) @(negedge clk);
        chk("midrst_dones", done_cnt - d0, 0);
        run_op(8'h0F, 8'h01, 8'h10, 1'b0, "after_rst");

        // Held start: one operation every WIDTH+3 cycles.
        d0 = done_cnt;
        q0 = done_times.size();
        a_in = 8'h80; b_in = 8'h80; start = 1'b1;
        repeat (30) begin
            @(negedge clk);
            if (done) begin
                chk("held_sum", sum_out, 8'h00);
                chk("held_cout", cout, 1'b1);
            end
        end
        start = 1'b0;
        repeat (15) begin
            @(negedge clk);
            if (done) chk("held_tail_sum", sum_out, 8'h00);
        end
        chk("held_dones", done_cnt - d0, 3);
        for (int i = q0 + 1; i < done_times.size(); i++)
            chk("held_gap", done_times[i] - done_times[i-1], WIDTH + 3);

        // Random traffic, including starts while busy and rare resets.
        repeat (3000) begin
            @(negedge clk);
            a_in  = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom);
            b_in  = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            start = ($urandom_range(0, 3) == 0);
            rst   = ($urandom_range(0, 199) != 0);
        end
        rst = 1'b1;
        start = 1'b0;
        repeat (15) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
